gobou_ctrl_mac: RTL and testbench
=================================

// Module: gobou_ctrl_mac
// PURPOSE
//  Control stage of the gobou MAC (multiply-accumulate) path; sits directly upstream of the bias control stage.
//  - Consumes the core controller's ctrl_bus: start = layer begin, valid = input beat, stop = layer end.
//  - Groups valid beats into dot products of n_in beats and drives the multiplier/accumulator enables.
//  - Emits a ctrl_bus to the bias stage with one valid pulse per completed accumulation.
// PARAMETERS
//  D_MUL  2   multiplier pipeline latency (cycles from input beat to product at accumulator input); >=1
//  CNTW   16  width of the beat counter and of n_in
// PORTS
//  clk       in   1     clock; all logic on posedge
//  rst       in   1     synchronous reset, active-high
//  in_ctrl   in   bus   ctrl_bus.slave {start,valid,stop} from core controller
//  n_in      in   CNTW  beats per dot product; sampled only on in_ctrl.start
//  out_ctrl  out  bus   ctrl_bus.master {start,valid,stop} to bias stage
//  mac_en    out  1     accumulator enable: add product this cycle
//  mac_clr   out  1     accumulator load: overwrite with product instead of adding
//  busy      out  1     high from accepted start until out_ctrl.stop issued
//  err       out  1     sticky protocol error (only with GOBOU_CTRL_MAC_CHECK_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, delay line cleared. Reset mid-layer aborts with no stop emitted.
//  - FSM states:
//    IDLE: start -> ACC; latch n_in (0 treated as 1); cnt <= 0.
//    ACC, on valid: cnt++. When cnt == n_lat-1, the beat is tagged last and cnt <= 0.
//    ACC, on stop: -> DRAIN. If the beat count is nonzero, the most recent beat is retagged last (partial group flushed).
//    DRAIN: count D_MUL+1 cycles, then -> IDLE.
//  - Simultaneous events:
//    valid+stop in the same cycle: the beat is counted first, then stop applies.
//    start while not IDLE: ignored. valid in IDLE/DRAIN: ignored.
//  - Beat tags {first,valid,last,start,stop} enter a D_MUL+1-deep delay line at the input cycle t:
//    mac_en  = valid tag at t+D_MUL
//    mac_clr = first tag at t+D_MUL (first beat of every group)
//    out_ctrl.valid = last tag at t+D_MUL+1, a 1-cycle pulse aligned with the accumulator holding the full sum
//    out_ctrl.start = start tag at t+D_MUL+1
//    out_ctrl.stop  = 1-cycle pulse on the DRAIN->IDLE cycle, never earlier than the final out_ctrl.valid
//  - Partial-flush case: a retag after the last beat has already entered the line sets the last tag in the stage holding that beat.
//  - Arithmetic: cnt is unsigned CNTW; compare against n_lat-1; no wrap, since cnt clears at group end.
//  - Bias stage follows with its own fixed ctrl delay; this block guarantees the 1-cycle alignment of out_ctrl.valid with the sum.
// CONFIGURATION
//  GOBOU_CTRL_MAC_CHECK_EN defined:
//    err is set sticky (cleared only by rst) on: start while busy, valid outside ACC, stop outside ACC.
//  GOBOU_CTRL_MAC_CHECK_EN undefined:
//    err is tied 0 and no check logic is built; the violations above are still silently ignored.
// STRUCTURE
//  gobou_pkg: D_MUL default, ctrl_reg struct {start,valid,stop}, mac_state_t enum {IDLE,ACC,DRAIN}, mac_tag_t struct.
//  Sub-module gobou_ctrl_delay: generic DEPTH-stage mac_tag_t shift line with synchronous active-high clear.
//  Top level holds the FSM, counters and output taps.
// TESTING
//  1 n_in=4, start then 8 consecutive valids, stop with beat 8:
//    -> mac_clr on beats 1,5 (+2 cyc); mac_en 8 cyc; out valid at beat4+3 and beat8+3; stop after.
//  2 n_in=3, valids with 1-cycle gaps:
//    -> out valid 3 cycles after each 3rd beat only; mac_en follows gaps exactly.
//  3 n_in=4, 6 valids then stop:
//    -> 2 out valids (after beats 4 and 6); mac_clr on beats 1,5.
//  4 n_in=0, 3 valids -> treated as 1: mac_clr on every beat, 3 out valids.
//  5 start during ACC, valid in IDLE:
//    -> ignored, counts unchanged; err=1 with macro, err=0 without.
//  6 rst asserted mid-ACC after 2 beats:
//    -> next cycle all outputs 0, busy 0; new layer starts clean with cnt=0.

Source files
------------

// File: rtl/gobou_pkg.sv
// rtl/gobou_pkg.sv - shared types for the gobou MAC control path
package gobou_pkg;

   localparam int D_MUL_DEF = 2;
   localparam int CNTW_DEF  = 16;

   typedef struct packed {
      logic start;
      logic valid;
      logic stop;
   } ctrl_reg;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DRAIN
   } mac_state_t;

   typedef struct packed {
      logic first;
      logic valid;
      logic last;
      logic start;
      logic stop;
   } mac_tag_t;

endpackage

// File: rtl/gobou_ctrl_delay.sv
// rtl/gobou_ctrl_delay.sv - DEPTH-stage beat tag shift line with synchronous clear
// retag[k] forces the last flag into stage k as it is loaded, for late partial-group flushes.
module gobou_ctrl_delay
   import gobou_pkg::*;
#(
   parameter int DEPTH = D_MUL_DEF + 1
) (
   input  logic                   clk,
   input  logic                   clr,
   input  mac_tag_t               din,
   input  logic [DEPTH-1:0]       retag,
   output mac_tag_t [DEPTH-1:0]   line
);

   mac_tag_t [DEPTH-1:0] line_nxt;

   always_comb begin
      line_nxt = {line[DEPTH-2:0], din};
      for (int k = 0; k < DEPTH; k++) begin
         line_nxt[k].last = line_nxt[k].last | retag[k];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         line <= '0;
      end else begin
         line <= line_nxt;
      end
   end

endmodule

// File: rtl/gobou_ctrl_mac.sv
// rtl/gobou_ctrl_mac.sv - MAC control stage: groups beats into dot products, drives accumulator enables
// Optional protocol checker built only when GOBOU_CTRL_MAC_CHECK_EN is defined; otherwise err is tied 0.
module gobou_ctrl_mac
   import gobou_pkg::*;
#(
   parameter int D_MUL = D_MUL_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  ctrl_reg         in_ctrl,
   input  logic [CNTW-1:0] n_in,
   output ctrl_reg         out_ctrl,
   output logic            mac_en,
   output logic            mac_clr,
   output logic            busy,
   output logic            err
);

   localparam int DEPTH = D_MUL + 1;
   localparam int AGEW  = $clog2(D_MUL + 2) + 1;

   mac_state_t           state, state_nxt;
   logic [CNTW-1:0]      cnt, cnt_nxt, n_lat;
   logic [AGEW-1:0]      drain_cnt, age;
   logic [DEPTH-1:0]     age_mask, retag;
   mac_tag_t             tag_in;
   mac_tag_t [DEPTH-1:0] line;
   logic                 drain_done;

   assign drain_done = (state == DRAIN) && (drain_cnt == AGEW'(D_MUL));

   always_comb begin
      age_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age_mask[k] = (age == AGEW'(k));
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tag_in    = '0;
      retag     = '0;
      case (state)
         IDLE: begin
            if (in_ctrl.start) begin
               state_nxt    = ACC;
               cnt_nxt      = '0;
               tag_in.start = 1'b1;
            end
         end
         ACC: begin
            if (in_ctrl.valid) begin
               tag_in.valid = 1'b1;
               tag_in.first = (cnt == '0);
               if (cnt == n_lat - CNTW'(1)) begin
                  tag_in.last = 1'b1;
                  cnt_nxt     = '0;
               end else begin
                  cnt_nxt = cnt + CNTW'(1);
               end
            end
            if (in_ctrl.stop) begin
               state_nxt   = DRAIN;
               tag_in.stop = 1'b1;
               cnt_nxt     = '0;
               // Flush a partial group: tag the newest beat directly, in the line, or by
               // injecting a bare last tag if that beat has already left the line.
               if (in_ctrl.valid) begin
                  if (cnt != n_lat - CNTW'(1)) tag_in.last = 1'b1;
               end else if (cnt != '0) begin
                  if (age <= AGEW'(D_MUL)) retag = age_mask;
                  else tag_in.last = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (drain_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         n_lat     <= '0;
         drain_cnt <= '0;
         age       <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && in_ctrl.start) begin
            n_lat <= (n_in == '0) ? CNTW'(1) : n_in;
         end
         drain_cnt <= (state == DRAIN) ? drain_cnt + AGEW'(1) : '0;
         // Cycles since the newest accepted beat, saturating once it has left the line.
         if (state == ACC && in_ctrl.valid) begin
            age <= AGEW'(1);
         end else if (age <= AGEW'(D_MUL)) begin
            age <= age + AGEW'(1);
         end
      end
   end

   gobou_ctrl_delay #(
      .DEPTH (DEPTH)
   ) u_delay (
      .clk   (clk),
      .clr   (rst),
      .din   (tag_in),
      .retag (retag),
      .line  (line)
   );

   assign mac_en         = line[D_MUL-1].valid;
   assign mac_clr        = line[D_MUL-1].first;
   assign out_ctrl.valid = line[D_MUL].last;
   assign out_ctrl.start = line[D_MUL].start;
   assign out_ctrl.stop  = drain_done;
   assign busy           = (state != IDLE);

`ifdef GOBOU_CTRL_MAC_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if ((in_ctrl.start && state != IDLE) ||
                   ((in_ctrl.valid || in_ctrl.stop) && state != ACC)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gobou_ctrl_mac.sv
// tb/tb_gobou_ctrl_mac.sv - scoreboard bench for gobou_ctrl_mac with a cycle-event reference model
module tb_gobou_ctrl_mac;
   import gobou_pkg::*;

   localparam int D    = 2;
   localparam int NCYC = 8192;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   ctrl_reg     in_ctrl = '0;
   logic [15:0] n_in = '0;
   ctrl_reg     out_ctrl;
   logic        mac_en, mac_clr, busy, err;

   gobou_ctrl_mac #(.D_MUL(D), .CNTW(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_ctrl  (in_ctrl),
      .n_in     (n_in),
      .out_ctrl (out_ctrl),
      .mac_en   (mac_en),
      .mac_clr  (mac_clr),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;
   int mon_start = 1 << 30;

   // Expected pulse cycles: 0 mac_en, 1 mac_clr, 2 out valid, 3 out start, 4 out stop
   int qs[5][$];
   bit exp_busy[NCYC];
   bit exp_err[NCYC];
   bit exp_rst[NCYC];

   // Reference model: layer-level view of the control protocol
   int m_mode = 0;       // 0 idle, 1 accumulating, 2 draining
   int m_n = 1, m_k = 0, m_last = 0, m_drain_end = 0;
   bit m_err = 0;

   task automatic model(input int c, input bit r, input bit s, input bit v, input bit p, input int n);
      int nxt = c + 1;
      if (r) begin
         m_mode = 0;
         m_k    = 0;
         m_err  = 0;
         for (int i = 0; i < 5; i++)
            while (qs[i].size() != 0 && qs[i][$] >= nxt) void'(qs[i].pop_back());
         exp_rst[nxt]  = 1;
         exp_busy[nxt] = 0;
         exp_err[nxt]  = 0;
         return;
      end
      if (m_mode == 2 && c > m_drain_end) m_mode = 0;
`ifdef GOBOU_CTRL_MAC_CHECK_EN
      if (s && m_mode != 0) m_err = 1;
      if ((v || p) && m_mode != 1) m_err = 1;
`endif
      if (m_mode == 0) begin
         if (s) begin
            m_n    = (n == 0) ? 1 : n;
            m_k    = 0;
            m_mode = 1;
            qs[3].push_back(c + D + 1);
         end
      end else if (m_mode == 1) begin
         if (v) begin
            qs[0].push_back(c + D);
            if (m_k == 0) qs[1].push_back(c + D);
            m_k++;
            m_last = c;
            if (m_k == m_n) begin
               qs[2].push_back(c + D + 1);
               m_k = 0;
            end
         end
         if (p) begin
            // Partial group: result marked at the newest beat's slot if still reachable, else asap
            if (m_k != 0) qs[2].push_back((c - m_last <= D) ? m_last + D + 1 : c + D + 1);
            m_k         = 0;
            m_mode      = 2;
            m_drain_end = c + D + 1;
            qs[4].push_back(c + D + 1);
         end
      end
      exp_busy[nxt] = (m_mode == 1) || (m_mode == 2 && nxt <= m_drain_end);
      exp_err[nxt]  = m_err;
   endtask

   task automatic step(input bit r, input bit s, input bit v, input bit p, input int n);
      @(posedge clk);
      #1;
      rst     = r;
      in_ctrl = '{start: s, valid: v, stop: p};
      n_in    = n[15:0];
      model(cyc, r, s, v, p, n);
      if (mon_start > cyc + 1) mon_start = cyc + 1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
   endtask

   task automatic ev(input int i, input string name, input bit sig, input int c);
      if (sig) begin
         checks++;
         if (qs[i].size() != 0 && qs[i][0] == c) begin
            passes++;
            void'(qs[i].pop_front());
         end else begin
            $display("FAIL %s unexpected pulse cycle=%0d actual=1 required=0 (next expected %0d)",
                     name, c, (qs[i].size() != 0) ? qs[i][0] : -1);
         end
      end else if (qs[i].size() != 0 && qs[i][0] <= c) begin
         checks++;
         $display("FAIL %s missing pulse cycle=%0d actual=0 required=1", name, qs[i][0]);
         void'(qs[i].pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= mon_start && cyc < NCYC) begin
         if (exp_rst[cyc])
            chk("reset_outputs", int'({mac_en, mac_clr, busy, err, out_ctrl}), 0);
         ev(0, "mac_en", mac_en, cyc);
         ev(1, "mac_clr", mac_clr, cyc);
         ev(2, "out_valid", out_ctrl.valid, cyc);
         ev(3, "out_start", out_ctrl.start, cyc);
         ev(4, "out_stop", out_ctrl.stop, cyc);
         chk("busy", int'(busy), int'(exp_busy[cyc]));
         chk("err", int'(err), int'(exp_err[cyc]));
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // 1: n=4, 8 back-to-back beats, stop with beat 8
      step(0, 1, 0, 0, 4);
      for (int i = 1; i <= 8; i++) step(0, 0, 1, i == 8, 0);
      idle(5);

      // 2: n=3, beats with 1-cycle gaps
      step(0, 1, 0, 0, 3);
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 1, 0);
      idle(5);

      // 3: n=4, 6 beats then stop (partial flush of beats 5,6)
      step(0, 1, 0, 0, 4);
      for (int i = 1; i <= 6; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      idle(5);

      // 4: n=0 behaves as 1
      step(0, 1, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      idle(5);

      // 5: valid in IDLE, start during ACC, valid during DRAIN
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 2);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 7);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      idle(5);

      // Late flush: partial beat already out of the delay line when stop arrives
      step(0, 1, 0, 0, 4);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      idle(5);
      step(0, 0, 0, 1, 0);
      idle(5);

      // 6: reset mid-layer after 2 beats, then a clean layer
      step(0, 1, 0, 0, 3);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 2);
      for (int i = 1; i <= 4; i++) step(0, 0, 1, i == 4, 0);
      idle(5);

      // Randomized layers, including spurious controls, stop timing and occasional resets
      for (int l = 0; l < 40; l++) begin
         int n, nb;
         bit stopped;
         if ($urandom_range(0, 9) == 0) step(1, 0, 0, 0, 0);
         n  = $urandom_range(0, 5);
         nb = $urandom_range(0, 12);
         stopped = 0;
         step(0, 1, $urandom_range(0, 7) == 0, 0, n);
         for (int b = 0; b < nb; b++) begin
            bit p = (b == nb - 1) && ($urandom_range(0, 1) == 1);
            bit r = ($urandom_range(0, 59) == 0);
            step(r, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, p, $urandom_range(0, 5));
            if (p) stopped = 1;
         end
         if (!stopped) begin
            idle($urandom_range(0, 4));
            step(0, 0, $urandom_range(0, 1), 1, 0);
         end
         for (int g = $urandom_range(0, 5); g > 0; g--)
            step(0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 1);
      end

      idle(10);
      @(negedge clk);
      #1;
      for (int i = 0; i < 5; i++) chk("queue_drained", qs[i].size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
